// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: RISC-V width codes,
// FSM state encoding and data-memory read/write control levels.
package lsu_pkg;

    // Load width/sign codes (funct3 of LOAD instructions)
    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_funct3_e;

    // Store width codes (funct3 of STORE instructions)
    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } store_funct3_e;

    // LSU control states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    // Data-memory control levels on mem_memrw
    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    // Width code parked on the memory port after reset (word)
    localparam logic [2:0] F3_RESET = 3'b010;

    // Address LSBs that must be zero for an access of the given width code:
    // bytes need none, halfwords bit 0, words bits 1:0.
    function automatic logic [1:0] align_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b01:   return 2'b01;
            2'b10:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the LSU's pipeline request/response handshake and its
// data-memory port. The slave view belongs to the LSU; the master view is
// the surrounding pipeline plus memory.
interface lsu_if #(
    parameter int NBIT = 32
) ();

    // Pipeline request
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [NBIT-1:0] req_base;
    logic [NBIT-1:0] req_offset;
    logic [NBIT-1:0] req_wdata;

    // Pipeline response
    logic            resp_valid;
    logic            resp_ready;
    logic [NBIT-1:0] resp_rdata;
    logic            resp_err;

    // Data memory
    logic [NBIT-1:0] mem_addr;
    logic [NBIT-1:0] mem_wdata;
    logic            mem_memrw;
    logic [2:0]      mem_funct3;
    logic [NBIT-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_base, req_offset, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_memrw, mem_funct3
    );

    modport master (
        output req_valid, req_we, req_funct3, req_base, req_offset, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_memrw, mem_funct3
    );

endinterface

// File: rtl/lsu_align_check.sv
// Effective-address adder and request legality check. Purely combinational:
// the address wraps modulo 2^NBIT, and a request is rejected when its width
// code is not a valid load/store code or the address is not naturally
// aligned for the access width.
module lsu_align_check
    import lsu_pkg::*;
#(
    parameter int NBIT = 32
) (
    input  logic [NBIT-1:0] base,
    input  logic [NBIT-1:0] offset,
    input  logic            we,
    input  logic [2:0]      funct3,
    output logic [NBIT-1:0] addr,
    output logic            err
);

    logic misaligned;
    logic bad_code;

    assign addr       = base + offset;
    assign misaligned = |(addr[1:0] & align_mask(funct3));

    // Width-code legality differs between loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW)
    always_comb begin
        bad_code = 1'b0;
        if (we) begin
            case (store_funct3_e'(funct3))
                F3_SB, F3_SH, F3_SW: bad_code = 1'b0;
                default:             bad_code = 1'b1;
            endcase
        end else begin
            case (load_funct3_e'(funct3))
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: bad_code = 1'b0;
                default:                             bad_code = 1'b1;
            endcase
        end
    end

    assign err = misaligned | bad_code;

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one pipeline memory request at a time, performs
// a single-cycle access on a combinational-read data memory, and returns a
// registered response. Illegal or misaligned requests skip the memory and
// answer one cycle earlier with resp_err set.
module lsu
    import lsu_pkg::*;
#(
    parameter int NBIT = 32
) (
    input  logic clk,
    input  logic rst_n,
    lsu_if.slave bus
);

    state_e          state_reg;
    state_e          state_next;

    logic            we_reg;
    logic [NBIT-1:0] mem_addr_reg;
    logic [NBIT-1:0] mem_wdata_reg;
    logic [2:0]      mem_funct3_reg;
    logic            resp_valid_reg;
    logic            resp_err_reg;
    logic [NBIT-1:0] resp_rdata_reg;

    logic [NBIT-1:0] chk_addr;
    logic            chk_err;
    logic            accept;

    lsu_align_check #(
        .NBIT (NBIT)
    ) u_align_check (
        .base   (bus.req_base),
        .offset (bus.req_offset),
        .we     (bus.req_we),
        .funct3 (bus.req_funct3),
        .addr   (chk_addr),
        .err    (chk_err)
    );

    // Requests are only taken while idle; RESP never overlaps with a new accept
    assign accept = (state_reg == ST_IDLE) && bus.req_valid;

    // Next-state logic plus the combinational handshake and write strobe
    always_comb begin
        state_next    = state_reg;
        bus.req_ready = 1'b0;
        bus.mem_memrw = MEM_READ;
        case (state_reg)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_next = chk_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Reset must be able to kill a store mid-cycle before the memory edge
                if (we_reg && rst_n) begin
                    bus.mem_memrw = MEM_WRITE;
                end
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Request capture, memory-port registers and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_reg         <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_funct3_reg <= F3_RESET;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        we_reg <= bus.req_we;
                        if (chk_err) begin
                            // Rejected requests leave the memory port untouched
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b1;
                            resp_rdata_reg <= '0;
                        end else begin
                            mem_addr_reg   <= chk_addr;
                            mem_wdata_reg  <= bus.req_wdata;
                            mem_funct3_reg <= bus.req_funct3;
                        end
                    end
                end
                ST_ACCESS: begin
                    resp_valid_reg <= 1'b1;
                    resp_err_reg   <= 1'b0;
                    resp_rdata_reg <= we_reg ? '0 : bus.mem_rdata;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        resp_err_reg   <= 1'b0;
                        resp_rdata_reg <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
    assign bus.mem_funct3 = mem_funct3_reg;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_err   = resp_err_reg;
    assign bus.resp_rdata = resp_rdata_reg;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for the LSU: directed scenarios plus randomized
// requests, all checked against a byte-level reference memory model.
module tb_lsu;
    import lsu_pkg::*;

    localparam int NBIT = 32;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    lsu_if #(.NBIT(NBIT)) bus ();

    lsu #(.NBIT(NBIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Environment memory (what the DUT really talks to), 256 bytes, aliased on addr[7:0]
    bit [7:0] env_mem [256];
    // Reference memory, updated only from the transaction-level model
    bit [7:0] ref_mem [256];

    logic [31:0] last_addr = 32'h0;
    logic [31:0] r_data;
    logic [31:0] r_addr;
    logic        r_err;

    // Environment memory write port: writes on the edge while mem_memrw is low
    always @(posedge clk) begin
        if (bus.mem_memrw === 1'b0) begin
            for (int i = 0; i < 4; i++) begin
                if (i < (1 << bus.mem_funct3[1:0]))
                    env_mem[8'(bus.mem_addr + 32'(i))] <= bus.mem_wdata[8*i +: 8];
            end
        end
    end

    // Environment memory combinational read with width/sign extension
    always_comb begin
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < (1 << bus.mem_funct3[1:0]))
                v[8*i +: 8] = env_mem[8'(bus.mem_addr + 32'(i))];
        end
        if (!bus.mem_funct3[2]) begin
            if (bus.mem_funct3[1:0] == 2'b00)      v[31:8]  = {24{v[7]}};
            else if (bus.mem_funct3[1:0] == 2'b01) v[31:16] = {16{v[15]}};
        end
        bus.mem_rdata = v;
    end

    // ---------------- reference model ----------------
    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (we) begin
            if (f3 > 3'd2) return 1'b1;
        end else if (f3 == 3'd3 || f3 >= 3'd6) begin
            return 1'b1;
        end
        size = 1 << f3[1:0];
        return (a % 32'(size)) != 32'd0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int size;
        logic [31:0] v;
        size = 1 << f3[1:0];
        v = 32'd0;
        for (int i = 0; i < size; i++)
            v = v + (32'(ref_mem[8'(a + 32'(i))]) << (8 * i));
        if (!f3[2] && size < 4 && v[8*size-1])
            v = v - (32'd1 << (8 * size));
        return v;
    endfunction

    function automatic void model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int size;
        size = 1 << f3[1:0];
        for (int i = 0; i < size; i++)
            ref_mem[8'(a + 32'(i))] = 8'(d >> (8 * i));
    endfunction

    // One complete request/response transaction with all per-transaction checks
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] base,
                          input logic [31:0] off, input logic [31:0] wdata, input int stall,
                          input string name, output logic [31:0] got_rdata,
                          output logic got_err, output logic [31:0] got_addr);
        logic [31:0] addr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
        int          exp_lat;
        int          low_cnt;
        int          exp_low;
        addr      = base + off;
        exp_err   = model_err(we, f3, addr);
        exp_rdata = (!we && !exp_err) ? model_load(f3, addr) : 32'h0;
        exp_lat   = exp_err ? 1 : 2;
        exp_low   = (we && !exp_err) ? 1 : 0;
        got_addr  = 32'h0;

        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s req_ready_idle: got %b want 1", name, bus.req_ready);
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_base   = base;
        bus.req_offset = off;
        bus.req_wdata  = wdata;
        @(posedge clk);
        if (!exp_err) begin
            last_addr = addr;
            if (we) model_store(f3, addr, wdata);
        end

        lat     = 0;
        low_cnt = 0;
        do begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            lat++;
            if (bus.mem_memrw === 1'b0) low_cnt++;
            if (lat == 1) got_addr = bus.mem_addr;
            if (lat == 1 && !exp_err) begin
                n_cmp++;
                if (bus.mem_addr !== addr || bus.mem_funct3 !== f3 || (we && bus.mem_wdata !== wdata)) begin
                    n_bad++;
                    $display("FAIL %s mem_port: got addr=%08h f3=%03b wdata=%08h want addr=%08h f3=%03b wdata=%08h",
                             name, bus.mem_addr, bus.mem_funct3, bus.mem_wdata, addr, f3, wdata);
                end
            end
        end while (bus.resp_valid !== 1'b1 && lat < 8);

        n_cmp++;
        if (lat != exp_lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (bus.resp_err !== exp_err || bus.resp_rdata !== exp_rdata) begin
            n_bad++;
            $display("FAIL %s response: got err=%b rdata=%08h want err=%b rdata=%08h",
                     name, bus.resp_err, bus.resp_rdata, exp_err, exp_rdata);
        end
        got_rdata = bus.resp_rdata;
        got_err   = bus.resp_err;

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (bus.mem_memrw === 1'b0) low_cnt++;
            n_cmp++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== got_rdata ||
                bus.resp_err !== got_err || bus.req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL %s hold[%0d]: got valid=%b err=%b rdata=%08h ready=%b want valid=1 err=%b rdata=%08h ready=0",
                         name, s, bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.req_ready, got_err, got_rdata);
            end
        end

        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        if (bus.mem_memrw === 1'b0) low_cnt++;
        n_cmp++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s consume: got valid=%b ready=%b want valid=0 ready=1",
                     name, bus.resp_valid, bus.req_ready);
        end
        n_cmp++;
        if (low_cnt != exp_low) begin
            n_bad++;
            $display("FAIL %s write_cycles: got %0d want %0d", name, low_cnt, exp_low);
        end
        n_cmp++;
        if (bus.mem_addr !== last_addr) begin
            n_bad++;
            $display("FAIL %s mem_addr_hold: got %08h want %08h", name, bus.mem_addr, last_addr);
        end
        $display("txn %s we=%0b f3=%03b addr=%08h err=%0b rdata=%08h lat=%0d",
                 name, we, f3, addr, got_err, got_rdata, lat);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_base   = 32'h0;
        bus.req_offset = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b0;
        rst_n          = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.mem_memrw !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_memrw_forced: got %b want 1", bus.mem_memrw);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.mem_memrw !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ctrl: got ready=%b valid=%b err=%b memrw=%b want 1 0 0 1",
                     bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_memrw);
        end
        n_cmp++;
        if (bus.resp_rdata !== 32'h0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_funct3 !== 3'b010) begin
            n_bad++;
            $display("FAIL reset_data: got rdata=%08h addr=%08h wdata=%08h f3=%03b want 0 0 0 010",
                     bus.resp_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_funct3);
        end
        last_addr = 32'h0;
    endtask

    task automatic test_store_load();
        do_req(1'b1, F3_SW, 32'h10, 32'h4, 32'hDEADBEEF, 0, "sw_14", r_data, r_err, r_addr);
        do_req(1'b0, F3_LW, 32'h14, 32'h0, 32'h0, 0, "lw_14", r_data, r_err, r_addr);
        n_cmp++;
        if (r_data !== 32'hDEADBEEF || r_err !== 1'b0) begin
            n_bad++;
            $display("FAIL store_load: got rdata=%08h err=%b want DEADBEEF 0", r_data, r_err);
        end
    endtask

    task automatic test_sign_ext();
        do_req(1'b1, F3_SB, 32'h20, 32'h0, 32'h00000080, 0, "sb_20", r_data, r_err, r_addr);
        do_req(1'b0, F3_LB, 32'h20, 32'h0, 32'h0, 0, "lb_20", r_data, r_err, r_addr);
        n_cmp++;
        if (r_data !== 32'hFFFFFF80) begin
            n_bad++;
            $display("FAIL lb_sign: got %08h want FFFFFF80", r_data);
        end
        do_req(1'b0, F3_LBU, 32'h20, 32'h0, 32'h0, 0, "lbu_20", r_data, r_err, r_addr);
        n_cmp++;
        if (r_data !== 32'h00000080) begin
            n_bad++;
            $display("FAIL lbu_zero: got %08h want 00000080", r_data);
        end
    endtask

    task automatic test_misaligned();
        do_req(1'b0, F3_LW, 32'h22, 32'h0, 32'h0, 0, "lw_22", r_data, r_err, r_addr);
        n_cmp++;
        if (r_err !== 1'b1 || r_data !== 32'h0) begin
            n_bad++;
            $display("FAIL lw_misaligned: got err=%b rdata=%08h want 1 00000000", r_err, r_data);
        end
        do_req(1'b1, F3_SH, 32'h21, 32'h0, 32'h0000BEEF, 0, "sh_21", r_data, r_err, r_addr);
        n_cmp++;
        if (r_err !== 1'b1) begin
            n_bad++;
            $display("FAIL sh_misaligned: got err=%b want 1", r_err);
        end
    endtask

    task automatic test_backpressure();
        do_req(1'b0, F3_LW, 32'h14, 32'h0, 32'h0, 5, "lw_stall5", r_data, r_err, r_addr);
        do_req(1'b0, F3_LW, 32'h1, 32'h1, 32'h0, 5, "lw_err_stall5", r_data, r_err, r_addr);
    endtask

    task automatic test_wrap_illegal();
        do_req(1'b0, F3_LW, 32'hFFFFFFFC, 32'h8, 32'h0, 0, "lw_wrap", r_data, r_err, r_addr);
        n_cmp++;
        if (r_addr !== 32'h00000004 || r_err !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_addr: got addr=%08h err=%b want 00000004 0", r_addr, r_err);
        end
        do_req(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 0, "ld_f3_011", r_data, r_err, r_addr);
        n_cmp++;
        if (r_err !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal_load_code: got err=%b want 1", r_err);
        end
        do_req(1'b1, 3'b100, 32'h40, 32'h0, 32'h1, 0, "st_f3_100", r_data, r_err, r_addr);
        n_cmp++;
        if (r_err !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal_store_code: got err=%b want 1", r_err);
        end
    endtask

    task automatic test_reset_mid_store();
        do_req(1'b1, F3_SW, 32'h30, 32'h0, 32'hCAFEF00D, 0, "sw_30_prior", r_data, r_err, r_addr);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_SW;
        bus.req_base   = 32'h30;
        bus.req_offset = 32'h0;
        bus.req_wdata  = 32'h12345678;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst_n         = 1'b0;
        #1;
        n_cmp++;
        if (bus.mem_memrw !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_memrw: got %b want 1", bus.mem_memrw);
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        last_addr = 32'h0;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.mem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL abort_state: got ready=%b valid=%b addr=%08h want 1 0 00000000",
                     bus.req_ready, bus.resp_valid, bus.mem_addr);
        end
        do_req(1'b0, F3_LW, 32'h30, 32'h0, 32'h0, 0, "lw_30_after_abort", r_data, r_err, r_addr);
        n_cmp++;
        if (r_data !== 32'hCAFEF00D) begin
            n_bad++;
            $display("FAIL abort_contents: got %08h want CAFEF00D", r_data);
        end
    endtask

    task automatic test_reset_in_resp();
        int waited;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = F3_LH;
        bus.req_base   = 32'h23;
        bus.req_offset = 32'h0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        waited = 0;
        while (bus.resp_valid !== 1'b1 && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1) begin
            n_bad++;
            $display("FAIL resp_pending: got valid=%b err=%b want 1 1", bus.resp_valid, bus.resp_err);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_addr = 32'h0;
        @(negedge clk);
        n_cmp++;
        if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL resp_discard: got valid=%b err=%b ready=%b want 0 0 1",
                     bus.resp_valid, bus.resp_err, bus.req_ready);
        end
    endtask

    task automatic test_no_accept_on_consume();
        logic [31:0] exp;
        int waited;
        exp = model_load(F3_LW, 32'h14);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b111;
        bus.req_base   = 32'h0;
        bus.req_offset = 32'h0;
        @(negedge clk);
        // Error response now pending; keep a legal request presented while consuming
        bus.req_funct3 = F3_LW;
        bus.req_base   = 32'h14;
        bus.resp_ready = 1'b1;
        n_cmp++;
        if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1) begin
            n_bad++;
            $display("FAIL overlap_pending: got valid=%b err=%b want 1 1", bus.resp_valid, bus.resp_err);
        end
        @(negedge clk);
        bus.resp_ready = 1'b0;
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL no_same_cycle_accept: got ready=%b valid=%b want 1 0", bus.req_ready, bus.resp_valid);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL accept_next_idle: got ready=%b want 0", bus.req_ready);
        end
        waited = 0;
        while (bus.resp_valid !== 1'b1 && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exp || bus.resp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL overlap_resp: got valid=%b rdata=%08h err=%b want 1 %08h 0",
                     bus.resp_valid, bus.resp_rdata, bus.resp_err, exp);
        end
        last_addr = 32'h14;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic        we;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] wd;
        for (int n = 0; n < 40; n++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            base = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) base = base & 32'hFFFFFFFC;
            off  = 32'($urandom_range(0, 16)) - 32'd8;
            wd   = $urandom;
            do_req(we, f3, base, off, wd, $urandom_range(0, 2), "rand", r_data, r_err, r_addr);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_sign_ext();
        test_misaligned();
        test_backpressure();
        test_wrap_illegal();
        test_reset_mid_store();
        test_reset_in_resp();
        test_no_accept_on_consume();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
